pe_ctrl: RTL and testbench

Sequencer for the 5x5 convolution processing element. It streams kernel weights and then ifmap windows into the PE's shift-register files. For each window it steps the output-channel index across all loaded kernels and manages partial-sum read/accumulate timing. It sits between the SRAM stream reader and one `pe` instance, and owns every PE control input.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_ctrl_pipe.sv | 34 +++
 rtl/pe_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pe_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the 5x5 convolution PE sequencer.
package pe_pkg;

    localparam int KNL_SIZE    = 25;
    localparam int KNL_MAXNUM  = 16;
    localparam int PE_PIPE_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_KNL,
        ST_LD_IFMAP,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } pe_state_t;

    // Kernel counts above the PE capacity are silently limited to the capacity.
    function automatic logic [5:0] clamp_knls(input logic [5:0] req, input int max_knls);
        return (int'(req) > max_knls) ? 6'(max_knls) : req;
    endfunction

endpackage

// File: rtl/pe_ctrl_pipe.sv
// Two-stage delay line matching the PE kernel-address and MAC registers;
// stage 1 drives the psum read, stage 2 flags the finished result.
module pe_ctrl_pipe (
    input  logic       clk,
    input  logic       srst,
    input  logic       issue_valid,
    input  logic [4:0] issue_chnl,
    input  logic       disable_acc,
    output logic       psum_rd,
    output logic       out_valid,
    output logic [4:0] out_chnl
);

    logic       s1_valid;
    logic [4:0] s1_chnl;

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_valid  <= 1'b0;
            s1_chnl   <= '0;
            out_valid <= 1'b0;
            out_chnl  <= '0;
        end else begin
            s1_valid  <= issue_valid;
            s1_chnl   <= issue_chnl;
            out_valid <= s1_valid;
            out_chnl  <= s1_chnl;
        end
    end

    // s1_chnl is the psum address the top presents alongside psum_rd.
    assign psum_rd = s1_valid && !disable_acc;

endmodule

// File: rtl/pe_ctrl.sv
// Sequencer for the 5x5 convolution PE: loads kernels, streams ifmap windows, issues channels.
// Define PE_CTRL_PERF_EN to add the perf_busy_cyc / perf_stall_cyc counters.
module pe_ctrl #(
    parameter int KNL_SIZE   = pe_pkg::KNL_SIZE,
    parameter int KNL_MAXNUM = pe_pkg::KNL_MAXNUM,
    parameter int WIN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 start,
    input  logic [5:0]           cfg_num_knls,
    input  logic [WIN_WIDTH-1:0] cfg_num_win,
    input  logic                 cfg_first_ichnl,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 en_ld_knl,
    output logic                 en_ld_ifmap,
    output logic                 disable_acc,
    output logic [5:0]           num_knls,
    output logic [4:0]           cnt_ofmap_chnl,
    output logic                 psum_rd,
    output logic                 out_valid,
    output logic [4:0]           out_chnl,
    output logic                 busy,
    output logic                 done
`ifdef PE_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_busy_cyc,
    output logic [31:0]          perf_stall_cyc
`endif
);

    import pe_pkg::*;

    localparam logic [WIN_WIDTH-1:0] WIN_ONE = 1;

    pe_state_t            state;
    pe_state_t            state_next;
    logic [8:0]           word_cnt;
    logic [8:0]           knl_words;
    logic [WIN_WIDTH-1:0] win_cnt;
    logic [WIN_WIDTH-1:0] num_win;
    logic [1:0]           drain_cnt;
    logic                 issue_valid;

    assign knl_words = 9'(int'(num_knls) * KNL_SIZE);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        en_ld_knl   = 1'b0;
        en_ld_ifmap = 1'b0;
        issue_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (cfg_num_knls == '0 || cfg_num_win == '0) ? ST_DONE : ST_LD_KNL;
                end
            end
            ST_LD_KNL: begin
                in_ready  = 1'b1;
                en_ld_knl = in_valid;
                if (in_valid && word_cnt == knl_words - 9'd1) begin
                    state_next = ST_LD_IFMAP;
                end
            end
            ST_LD_IFMAP: begin
                in_ready    = 1'b1;
                en_ld_ifmap = in_valid;
                if (in_valid && word_cnt == 9'(KNL_SIZE - 1)) begin
                    state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                issue_valid = 1'b1;
                if ({1'b0, cnt_ofmap_chnl} == num_knls - 6'd1) begin
                    state_next = ST_DRAIN;
                end
            end
            // Re-entering LD_IFMAP only after the drain keeps the window intact for the last psum.
            ST_DRAIN: begin
                if (drain_cnt == 2'(PE_PIPE_LAT - 1)) begin
                    state_next = (win_cnt == num_win - WIN_ONE) ? ST_DONE : ST_LD_IFMAP;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state          <= ST_IDLE;
            done           <= 1'b0;
            word_cnt       <= '0;
            cnt_ofmap_chnl <= '0;
            win_cnt        <= '0;
            drain_cnt      <= '0;
            num_knls       <= '0;
            num_win        <= '0;
            disable_acc    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_knls       <= clamp_knls(cfg_num_knls, KNL_MAXNUM);
                        num_win        <= cfg_num_win;
                        disable_acc    <= cfg_first_ichnl;
                        word_cnt       <= '0;
                        cnt_ofmap_chnl <= '0;
                        win_cnt        <= '0;
                        drain_cnt      <= '0;
                    end
                end
                ST_LD_KNL, ST_LD_IFMAP: begin
                    if (in_valid) begin
                        word_cnt <= (state_next != state) ? 9'd0 : word_cnt + 9'd1;
                    end
                end
                ST_COMPUTE: begin
                    cnt_ofmap_chnl <= (state_next != state) ? 5'd0 : cnt_ofmap_chnl + 5'd1;
                end
                ST_DRAIN: begin
                    if (state_next != state) begin
                        drain_cnt <= '0;
                        win_cnt   <= win_cnt + WIN_ONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    pe_ctrl_pipe u_pipe (
        .clk         (clk),
        .srst        (srst),
        .issue_valid (issue_valid),
        .issue_chnl  (cnt_ofmap_chnl),
        .disable_acc (disable_acc),
        .psum_rd     (psum_rd),
        .out_valid   (out_valid),
        .out_chnl    (out_chnl)
    );

`ifdef PE_CTRL_PERF_EN
    // Counters restart only on an accepted start and stick at all-ones.
    always_ff @(posedge clk) begin
        if (srst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (state != ST_IDLE && perf_busy_cyc != '1) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if (in_ready && !in_valid && perf_stall_cyc != '1) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// Self-checking bench for pe_ctrl: per-cycle comparison against a job-level timeline model.
// Build with PE_CTRL_PERF_EN defined to also check the performance counters.
module tb_pe_ctrl;

    localparam int MAXT = 4096;

    logic        clk = 1'b0;
    logic        srst;
    logic        start;
    logic [5:0]  cfg_num_knls;
    logic [15:0] cfg_num_win;
    logic        cfg_first_ichnl;
    logic        in_valid;
    logic        in_ready, en_ld_knl, en_ld_ifmap, disable_acc;
    logic [5:0]  num_knls;
    logic [4:0]  cnt_ofmap_chnl;
    logic        psum_rd, out_valid, busy, done;
    logic [4:0]  out_chnl;
`ifdef PE_CTRL_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    int checks = 0;
    int errors = 0;

    bit vld_pat [MAXT];
    bit e_rdy   [MAXT];
    bit e_knl   [MAXT];
    bit e_ifm   [MAXT];
    bit e_issue [MAXT];
    bit e_psum  [MAXT];
    bit e_outv  [MAXT];
    int e_chnl  [MAXT];
    int e_outc  [MAXT];
    int e_done_t;
    int e_stalls;
    int n_knl, n_ifm, n_out, n_psum;

    always #5 clk = ~clk;

    pe_ctrl dut (
        .clk             (clk),
        .srst            (srst),
        .start           (start),
        .cfg_num_knls    (cfg_num_knls),
        .cfg_num_win     (cfg_num_win),
        .cfg_first_ichnl (cfg_first_ichnl),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .en_ld_knl       (en_ld_knl),
        .en_ld_ifmap     (en_ld_ifmap),
        .disable_acc     (disable_acc),
        .num_knls        (num_knls),
        .cnt_ofmap_chnl  (cnt_ofmap_chnl),
        .psum_rd         (psum_rd),
        .out_valid       (out_valid),
        .out_chnl        (out_chnl),
        .busy            (busy),
        .done            (done)
`ifdef PE_CTRL_PERF_EN
        ,
        .perf_busy_cyc   (perf_busy_cyc),
        .perf_stall_cyc  (perf_stall_cyc)
`endif
    );

    // mode 0: always valid, 1: valid on odd cycles, 2: random ~70% valid
    task automatic fill_pattern(input int mode);
        for (int t = 0; t < MAXT; t++) begin
            case (mode)
                0:       vld_pat[t] = 1'b1;
                1:       vld_pat[t] = (t % 2) == 1;
                default: vld_pat[t] = (t > 3000) ? 1'b1 : ($urandom_range(0, 9) < 7);
            endcase
        end
    endtask

    // Walk the job as phases: accept K*25 words, then per window 25 words, K issues, 2 drain cycles.
    task automatic build_model(input int k_cfg, input int w, input bit first);
        int k_eff, t, need;
        k_eff = (k_cfg > 16) ? 16 : k_cfg;
        for (int i = 0; i < MAXT; i++) begin
            e_rdy[i] = 0; e_knl[i] = 0; e_ifm[i] = 0; e_issue[i] = 0;
            e_psum[i] = 0; e_outv[i] = 0; e_chnl[i] = 0; e_outc[i] = 0;
        end
        e_stalls = 0;
        t = 1;
        if (k_eff == 0 || w == 0) begin
            e_done_t = 2;
        end else begin
            need = k_eff * 25;
            while (need > 0) begin
                e_rdy[t] = 1;
                if (vld_pat[t]) begin e_knl[t] = 1; need--; end else e_stalls++;
                t++;
            end
            for (int win = 0; win < w; win++) begin
                need = 25;
                while (need > 0) begin
                    e_rdy[t] = 1;
                    if (vld_pat[t]) begin e_ifm[t] = 1; need--; end else e_stalls++;
                    t++;
                end
                for (int c = 0; c < k_eff; c++) begin
                    e_issue[t] = 1;
                    e_chnl[t] = c;
                    e_psum[t + 1] = !first;
                    e_outv[t + 2] = 1;
                    e_outc[t + 2] = c;
                    t++;
                end
                t += 2;
            end
            e_done_t = t + 1;
        end
    endtask

    task automatic run_job(input int k_cfg, input int w, input bit first, input int mode,
                           input bit glitch);
        int k_eff;
        k_eff = (k_cfg > 16) ? 16 : k_cfg;
        fill_pattern(mode);
        build_model(k_cfg, w, first);
        n_knl = 0; n_ifm = 0; n_out = 0; n_psum = 0;
        for (int t = 0; t <= e_done_t + 1; t++) begin
            @(negedge clk);
            start = (t == 0) || (glitch && t == 10);
            if (t == 0) begin
                cfg_num_knls = 6'(k_cfg); cfg_num_win = 16'(w); cfg_first_ichnl = first;
            end else if (glitch && t == 10) begin
                cfg_num_knls = 6'd5; cfg_num_win = 16'd7; cfg_first_ichnl = !first;
            end
            in_valid = vld_pat[t];
            #1;
            n_knl += int'(en_ld_knl); n_ifm += int'(en_ld_ifmap);
            n_out += int'(out_valid); n_psum += int'(psum_rd);
            checks += 7;
            if (in_ready !== e_rdy[t]) begin errors++; $display("[TB] FAIL in_ready t=%0d got %b exp %b", t, in_ready, e_rdy[t]); end
            if (en_ld_knl !== e_knl[t]) begin errors++; $display("[TB] FAIL en_ld_knl t=%0d got %b exp %b", t, en_ld_knl, e_knl[t]); end
            if (en_ld_ifmap !== e_ifm[t]) begin errors++; $display("[TB] FAIL en_ld_ifmap t=%0d got %b exp %b", t, en_ld_ifmap, e_ifm[t]); end
            if (psum_rd !== e_psum[t]) begin errors++; $display("[TB] FAIL psum_rd t=%0d got %b exp %b", t, psum_rd, e_psum[t]); end
            if (out_valid !== e_outv[t]) begin errors++; $display("[TB] FAIL out_valid t=%0d got %b exp %b", t, out_valid, e_outv[t]); end
            if (done !== (t == e_done_t)) begin errors++; $display("[TB] FAIL done t=%0d got %b exp %b", t, done, t == e_done_t); end
            if (busy !== (t >= 1 && t < e_done_t)) begin errors++; $display("[TB] FAIL busy t=%0d got %b", t, busy); end
            if (e_outv[t]) begin
                checks++;
                if (out_chnl !== 5'(e_outc[t])) begin errors++; $display("[TB] FAIL out_chnl t=%0d got %0d exp %0d", t, out_chnl, e_outc[t]); end
            end
            if (e_issue[t]) begin
                checks++;
                if (cnt_ofmap_chnl !== 5'(e_chnl[t])) begin errors++; $display("[TB] FAIL cnt_ofmap_chnl t=%0d got %0d exp %0d", t, cnt_ofmap_chnl, e_chnl[t]); end
            end
            if (t >= 1) begin
                checks += 2;
                if (num_knls !== 6'(k_eff)) begin errors++; $display("[TB] FAIL num_knls t=%0d got %0d exp %0d", t, num_knls, k_eff); end
                if (disable_acc !== first) begin errors++; $display("[TB] FAIL disable_acc t=%0d got %b exp %b", t, disable_acc, first); end
            end
`ifdef PE_CTRL_PERF_EN
            if (t == e_done_t) begin
                checks += 2;
                if (perf_busy_cyc !== 32'(e_done_t - 1)) begin errors++; $display("[TB] FAIL perf_busy_cyc got %0d exp %0d", perf_busy_cyc, e_done_t - 1); end
                if (perf_stall_cyc !== 32'(e_stalls)) begin errors++; $display("[TB] FAIL perf_stall_cyc got %0d exp %0d", perf_stall_cyc, e_stalls); end
            end
`endif
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({in_ready, en_ld_knl, en_ld_ifmap, disable_acc, num_knls, cnt_ofmap_chnl,
             psum_rd, out_valid, out_chnl, busy, done} !== '0) begin
            errors++;
            $display("[TB] FAIL %s outputs not zero: rdy=%b knl=%b ifm=%b dacc=%b nk=%0d ch=%0d prd=%b ov=%b oc=%0d busy=%b done=%b",
                     tag, in_ready, en_ld_knl, en_ld_ifmap, disable_acc, num_knls, cnt_ofmap_chnl,
                     psum_rd, out_valid, out_chnl, busy, done);
        end
`ifdef PE_CTRL_PERF_EN
        checks++;
        if (perf_busy_cyc !== 32'd0 || perf_stall_cyc !== 32'd0) begin
            errors++; $display("[TB] FAIL %s perf got %0d/%0d exp 0/0", tag, perf_busy_cyc, perf_stall_cyc);
        end
`endif
    endtask

    task automatic test_reset;
        srst = 1'b1; start = 1'b0; in_valid = 1'b0;
        cfg_num_knls = '0; cfg_num_win = '0; cfg_first_ichnl = 1'b0;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        #1;
        check_all_zero("reset");
    endtask

    task automatic test_basic_accumulate;
        run_job(2, 1, 1'b0, 0, 1'b0);
        checks += 5;
        if (n_knl != 50) begin errors++; $display("[TB] FAIL basic knl_loads got %0d exp 50", n_knl); end
        if (n_ifm != 25) begin errors++; $display("[TB] FAIL basic ifmap_loads got %0d exp 25", n_ifm); end
        if (n_psum != 2) begin errors++; $display("[TB] FAIL basic psum_reads got %0d exp 2", n_psum); end
        if (n_out != 2) begin errors++; $display("[TB] FAIL basic results got %0d exp 2", n_out); end
        if (e_done_t != 81) begin errors++; $display("[TB] FAIL basic done_cycle model %0d exp 81", e_done_t); end
    endtask

    task automatic test_first_chnl;
        run_job(16, 3, 1'b1, 0, 1'b0);
        checks += 2;
        if (n_psum != 0) begin errors++; $display("[TB] FAIL first_chnl psum_reads got %0d exp 0", n_psum); end
        if (n_out != 48) begin errors++; $display("[TB] FAIL first_chnl results got %0d exp 48", n_out); end
    endtask

    task automatic test_stalls;
        run_job(1, 1, 1'b0, 1, 1'b0);
        checks += 2;
        if (n_knl != 25) begin errors++; $display("[TB] FAIL stalls knl_loads got %0d exp 25", n_knl); end
        if (n_ifm != 25) begin errors++; $display("[TB] FAIL stalls ifmap_loads got %0d exp 25", n_ifm); end
    endtask

    task automatic test_clamp;
        run_job(20, 1, 1'b0, 0, 1'b0);
        checks += 2;
        if (n_knl != 400) begin errors++; $display("[TB] FAIL clamp knl_loads got %0d exp 400", n_knl); end
        if (num_knls !== 6'd16) begin errors++; $display("[TB] FAIL clamp num_knls got %0d exp 16", num_knls); end
    endtask

    task automatic test_degenerate;
        run_job(0, 4, 1'b0, 0, 1'b0);
        run_job(3, 0, 1'b1, 0, 1'b0);
        checks++;
        if (n_knl + n_ifm + n_out != 0) begin errors++; $display("[TB] FAIL zero_win activity got %0d exp 0", n_knl + n_ifm + n_out); end
    endtask

    task automatic test_ignored_start;
        run_job(1, 2, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_job;
        int t_issue;
        fill_pattern(0);
        build_model(4, 2, 1'b1);
        t_issue = 0;
        for (int t = MAXT - 1; t >= 0; t--) if (e_issue[t]) t_issue = t;
        for (int t = 0; t <= t_issue + 2; t++) begin
            @(negedge clk);
            start = (t == 0);
            cfg_num_knls = 6'd4; cfg_num_win = 16'd2; cfg_first_ichnl = 1'b1;
            in_valid = 1'b1;
        end
        start = 1'b0;
        #1;
        checks++;
        if (cnt_ofmap_chnl !== 5'd2) begin errors++; $display("[TB] FAIL midjob cnt_ofmap_chnl got %0d exp 2", cnt_ofmap_chnl); end
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        #1;
        check_all_zero("reset_mid_job");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL post_reset done/busy got %b/%b exp 0/0", done, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random;
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_accumulate();
        test_first_chnl();
        test_stalls();
        test_clamp();
        test_degenerate();
        test_ignored_start();
        test_reset_mid_job();
        test_basic_accumulate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
